// File: rtl/seq_step_ctrl.sv
// Step-enable pacer for the LED sequencer: a speed-scaled divider produces one-cycle
// step pulses, with debounced run/pause and single-step pushbuttons.
module seq_step_ctrl #(
  parameter int DIV_BASE   = 50_000_000,
  parameter int DIV_WIDTH  = 26,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_run,
  input  logic                 key_step,
  input  logic [1:0]           sw_speed,
  output logic                 step_en,
  output logic                 running,
  output logic [CNT_WIDTH-1:0] step_count
);

  localparam int                   DEB_W      = $clog2(DEB_CYCLES);
  localparam logic [DEB_W-1:0]     DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0]     DEB_ONE    = DEB_W'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_BASE_V = DIV_WIDTH'(DIV_BASE);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE    = DIV_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  logic [1:0] key_raw;
  logic [1:0] press;   // bit 0 = run key, bit 1 = step key

  assign key_raw = {key_step, key_run};

  // Per key: 2-FF synchronizer, stability counter, falling-edge press pulse.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      logic             meta_q;
      logic             sync_q;
      logic             deb_q;
      logic             deb_dly_q;
      logic             press_q;
      logic [DEB_W-1:0] cnt_q;
      logic [DEB_W-1:0] cnt_d;
      logic             deb_d;

      always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync_q != deb_q) begin
          if (cnt_q == DEB_LAST) begin
            deb_d = sync_q;
          end else begin
            cnt_d = cnt_q + DEB_ONE;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          meta_q    <= 1'b1;
          sync_q    <= 1'b1;
          deb_q     <= 1'b1;
          deb_dly_q <= 1'b1;
          press_q   <= 1'b0;
          cnt_q     <= '0;
        end else begin
          meta_q    <= key_raw[gi];
          sync_q    <= meta_q;
          deb_q     <= deb_d;
          cnt_q     <= cnt_d;
          deb_dly_q <= deb_q;
          press_q   <= deb_dly_q & ~deb_q;
        end
      end

      assign press[gi] = press_q;
    end
  endgenerate

  logic [1:0]           spd_meta_q;
  logic [1:0]           spd_sync_q;
  logic [DIV_WIDTH-1:0] limit_m1;
  logic [DIV_WIDTH-1:0] div_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 step_en_q;
  state_t               state_q;

  assign limit_m1 = (DIV_BASE_V >> spd_sync_q) - DIV_ONE;

  // ">=" rather than "==" so a speed increase never strands the count above the limit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      spd_meta_q <= 2'b00;
      spd_sync_q <= 2'b00;
      state_q    <= ST_RUN;
      div_q      <= '0;
      count_q    <= '0;
      step_en_q  <= 1'b0;
    end else begin
      spd_meta_q <= sw_speed;
      spd_sync_q <= spd_meta_q;
      step_en_q  <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (press[0]) begin
            state_q <= ST_PAUSE;
            div_q   <= '0;
          end else if (div_q >= limit_m1) begin
            step_en_q <= 1'b1;
            div_q     <= '0;
            count_q   <= count_q + CNT_ONE;
          end else begin
            div_q <= div_q + DIV_ONE;
          end
        end
        ST_PAUSE: begin
          div_q <= '0;
          if (press[0]) begin
            state_q <= ST_RUN;
          end else if (press[1]) begin
            step_en_q <= 1'b1;
            count_q   <= count_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_RUN;
          div_q   <= '0;
        end
      endcase
    end
  end

  assign step_en    = step_en_q;
  assign running    = (state_q == ST_RUN);
  assign step_count = count_q;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Directed-plus-random bench for seq_step_ctrl; expectations come from step periods
// (DIV_BASE >> speed) and counts of pulses the control rules call for.
module tb_seq_step_ctrl;
  localparam int DIV_BASE   = 16;
  localparam int DIV_WIDTH  = 8;
  localparam int DEB_CYCLES = 4;
  localparam int CNT_WIDTH  = 8;

  logic                 clk      = 1'b0;
  logic                 rst      = 1'b0;
  logic                 key_run  = 1'b1;
  logic                 key_step = 1'b1;
  logic [1:0]           sw_speed = 2'b00;
  logic                 step_en;
  logic                 running;
  logic [CNT_WIDTH-1:0] step_count;

  seq_step_ctrl #(
    .DIV_BASE  (DIV_BASE),
    .DIV_WIDTH (DIV_WIDTH),
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_run   (key_run),
    .key_step  (key_step),
    .sw_speed  (sw_speed),
    .step_en   (step_en),
    .running   (running),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   win_pulses = 0;
  int   win_falls = 0;
  int   win_rises = 0;
  int   doubles = 0;
  int   exp_count = 0;
  logic run_prev = 1'b1;
  logic en_prev = 1'b0;

  function automatic int period(input int s);
    return DIV_BASE >> s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("check %s obs=%0d exp=%0d", tag, obs, exp);
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (step_en) begin
      win_pulses++;
      if (en_prev) doubles++;
    end
    if (run_prev && !running) win_falls++;
    if (!run_prev && running) win_rises++;
    run_prev = running;
    en_prev  = step_en;
  endtask

  task automatic clear_win();
    win_pulses = 0;
    win_falls  = 0;
    win_rises  = 0;
  endtask

  task automatic mark_release();
    clear_win();
    exp_count = 0;
    cyc       = 0;
    run_prev  = running;
    en_prev   = step_en;
  endtask

  // Model expects one pulse per call; waited = ticks until it shows, -1 on timeout.
  task automatic wait_pulse(input int max, output int waited);
    waited = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (step_en) begin
        waited = i;
        break;
      end
    end
    exp_count = (exp_count + 1) % (1 << CNT_WIDTH);
  endtask

  initial begin
    int w;
    int bad;
    int s;
    int b;
    int h;
    int entered;

    // 1: reset values, base period, count wrap
    rst = 1'b0;
    tick(); tick(); tick();
    check("rst_step_en", step_en, 0);
    check("rst_running", running, 1);
    check("rst_count", step_count, 0);
    rst = 1'b1;
    mark_release();
    for (int k = 1; k <= 3; k++) begin
      wait_pulse(40, w);
      check("t1_interval", w, period(0));
      check("t1_count", step_count, exp_count);
    end
    bad = 0;
    for (int k = 4; k <= 256; k++) begin
      wait_pulse(20, w);
      if (w != period(0)) bad++;
    end
    check("t1_wrap_intervals", bad, 0);
    check("t1_wrap_count", step_count, exp_count);
    check("t1_wrap_zero", step_count, 0);

    // 2: speed changes, including lowering L below the current count
    repeat (10) tick();
    sw_speed = 2'd2;
    wait_pulse(8, w);
    check("t2_fast_first", (w >= 1 && w <= 5), 1);
    for (int k = 0; k < 4; k++) begin
      wait_pulse(10, w);
      check("t2_period4", w, period(2));
    end
    sw_speed = 2'd3;
    wait_pulse(8, w);
    check("t2_s3_first", (w > 0), 1);
    for (int k = 0; k < 3; k++) begin
      wait_pulse(6, w);
      check("t2_period2", w, period(3));
    end
    for (int r = 0; r < 4; r++) begin
      s = int'($urandom_range(0, 3));
      sw_speed = 2'(s);
      wait_pulse(24, w);
      check("t2_rand_first", (w > 0), 1);
      for (int k = 0; k < 2; k++) begin
        wait_pulse(24, w);
        check("t2_rand_period", w, period(s));
      end
    end
    check("t2_count", step_count, exp_count);

    // 3a: short bounces on key_run never register
    sw_speed = 2'd0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    mark_release();
    tick(); tick();
    b = int'($urandom_range(1, DEB_CYCLES - 1));
    key_run = 1'b0;
    repeat (b) tick();
    key_run = 1'b1;
    repeat (8) tick();
    b = int'($urandom_range(1, DEB_CYCLES - 1));
    key_run = 1'b0;
    repeat (b) tick();
    key_run = 1'b1;
    while (cyc < 40) tick();
    check("t3_bounce_falls", win_falls, 0);
    check("t3_bounce_running", running, 1);
    check("t3_bounce_pulses", win_pulses, 40 / period(0));
    check("t3_bounce_count", step_count, 40 / period(0));

    // 3b: clean run press pauses before the first divider pulse is due
    rst = 1'b0;
    tick();
    rst = 1'b1;
    mark_release();
    key_run = 1'b0;
    repeat (20) tick();
    key_run = 1'b1;
    repeat (40) tick();
    check("t3_pause_running", running, 0);
    check("t3_pause_falls", win_falls, 1);
    check("t3_pause_rises", win_rises, 0);
    check("t3_pause_pulses", win_pulses, 0);
    check("t3_pause_count", step_count, exp_count);

    // 4: single-step in PAUSE, long hold gives exactly one step
    clear_win();
    h = int'($urandom_range(60, 100));
    key_step = 1'b0;
    repeat (h) tick();
    key_step = 1'b1;
    repeat (20) tick();
    exp_count++;
    check("t4_hold_pulses", win_pulses, 1);
    check("t4_hold_count", step_count, exp_count);
    check("t4_hold_running", running, 0);
    clear_win();
    key_step = 1'b0;
    repeat (12) tick();
    key_step = 1'b1;
    repeat (20) tick();
    exp_count++;
    check("t4_second_pulses", win_pulses, 1);
    check("t4_second_count", step_count, exp_count);

    // 5: coincident run+step presses in PAUSE -> RUN, step discarded
    clear_win();
    key_run  = 1'b0;
    key_step = 1'b0;
    entered  = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (running) begin
        entered = i;
        break;
      end
    end
    key_run  = 1'b1;
    key_step = 1'b1;
    check("t5_entered_run", (entered > 0), 1);
    check("t5_entry_step_en", step_en, 0);
    check("t5_no_step", win_pulses, 0);
    wait_pulse(40, w);
    check("t5_first_pulse", w, period(0));
    check("t5_count", step_count, exp_count);
    // step key pressed while running adds nothing
    clear_win();
    key_step = 1'b0;
    repeat (20) tick();
    key_step = 1'b1;
    repeat (3 * period(0) - 20) tick();
    exp_count = (exp_count + 3) % (1 << CNT_WIDTH);
    check("t5_run_step_pulses", win_pulses, 3);
    check("t5_run_step_count", step_count, exp_count);
    check("t5_run_step_running", running, 1);

    // 6: one-cycle reset mid-run with a run press half debounced
    rst = 1'b0;
    tick();
    rst = 1'b1;
    mark_release();
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      wait_pulse(40, w);
      if (w != period(0)) bad++;
    end
    check("t6_pre_intervals", bad, 0);
    check("t6_pre_count", step_count, 5);
    repeat (4) tick();
    key_run = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    key_run = 1'b1;
    tick();
    check("t6_rst_step_en", step_en, 0);
    check("t6_rst_running", running, 1);
    check("t6_rst_count", step_count, 0);
    rst = 1'b1;
    mark_release();
    wait_pulse(40, w);
    check("t6_resume_first", w, period(0));
    wait_pulse(40, w);
    check("t6_resume_second", w, period(0));
    check("t6_no_press", win_falls, 0);
    check("t6_running", running, 1);
    check("t6_count", step_count, exp_count);

    check("no_double_pulse", doubles, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_step_ctrl.md
Name: seq_step_ctrl

Overview:
- Upstream pacing stage for the LED pattern sequencer.
- Turns the 50 MHz board clock into a one-cycle step enable, so the sequencer advances at a visible rate instead of once per clock.
- Adds run/pause and single-step control from two raw pushbuttons, plus a 2-bit speed select from switches.
- The sequencer advances its state only on cycles where step_en=1.

Parameters:
- DIV_BASE, 50_000_000, cycles per step at sw_speed=0 (1 Hz at 50 MHz); must be >=16.
- DIV_WIDTH, 26, width of the divider counter; must hold DIV_BASE-1.
- DEB_CYCLES, 1_000_000, consecutive stable cycles before a debounced key level changes (20 ms); must be >=2.
- CNT_WIDTH, 8, width of step_count.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low.
- key_run  input  1  raw pushbutton, active-low, asynchronous to clk; each press toggles run/pause.
- key_step  input  1  raw pushbutton, active-low, asynchronous; each press issues one step while paused.
- sw_speed  input  2  raw switches; step period = DIV_BASE >> sw_speed cycles.
- step_en  output  1  one-cycle step pulse to the sequencer, registered.
- running  output  1  1=RUN, 0=PAUSE.
- step_count  output  CNT_WIDTH  number of step_en pulses issued; wraps 2^CNT_WIDTH-1 -> 0.

Behaviour:
- Reset (rst=0 at a clk edge), values after that edge:
  - step_en=0, running=1 (state RUN), step_count=0, divider counter=0.
  - Key synchronizers and debounced key levels=1 (released).
  - Debounce counters=0; speed synchronizer=0.
  - Reset mid-operation aborts any pending step or press.
- Synchronization: each key and both sw_speed bits pass through a 2-FF synchronizer before use.
- Debounce, per key (s = synchronized level, d = debounced level):
  - If s!=d, the debounce counter increments.
  - When the counter reaches DEB_CYCLES-1 with s still !=d: d<=s, counter<=0.
  - If s==d, the counter clears.
  - Net effect: d changes only after DEB_CYCLES consecutive mismatching cycles.
- Press pulse: a registered one-cycle pulse on the clock after d goes 1->0. Release (0->1) produces nothing. Holding a key produces exactly one press.
- Divider limit L = DIV_BASE >> sw_speed_sync (1x, 2x, 4x, 8x rate).
- FSM states RUN and PAUSE:
  - RUN + run_press -> PAUSE.
  - PAUSE + run_press -> RUN.
  - step_press in RUN is ignored.
  - PAUSE + step_press, with no run_press in the same cycle -> step_en=1 on the next edge; state stays PAUSE.
  - run_press and step_press in the same cycle while in PAUSE: go to RUN; the step is discarded.
- Divider in RUN:
  - At each edge, if counter >= L-1: step_en<=1, counter<=0. Otherwise step_en<=0, counter<=counter+1.
  - Steady-state period is exactly L cycles.
  - The >= compare handles a speed change that lowers L below the current count: a pulse fires on the next edge, then the new period applies.
- Divider in PAUSE: counter held at 0. Entering RUN restarts from 0, so the first pulse comes L cycles later.
- Transition RUN->PAUSE: no step_en on the edge that enters PAUSE, even if the divider would have fired on that edge.
- step_count increments on every edge where step_en is set to 1, modulo 2^CNT_WIDTH.
- step_en is never high on two consecutive cycles.

Test Plan (bench parameters: DIV_BASE=16, DEB_CYCLES=4, CNT_WIDTH=8):
1. Release reset with sw_speed=0 and no keys -> running=1; step_en pulses every 16 cycles, the first 16 cycles after reset release. step_count reads 1, 2, 3 after the first three pulses. After 256 pulses step_count=0.
2. sw_speed=0 with counter at 10, then sw_speed=2 (L=4) -> one pulse within 3 cycles of the synchronized change, then pulses every 4 cycles. sw_speed=3 -> period 2.
3. key_run low 3 cycles then high (bounce) -> no press, running stays 1. key_run low for 20 cycles -> running=0 exactly once; no further step_en; divider counter=0.
4. In PAUSE, hold key_step low for 100 cycles -> exactly one step_en pulse; step_count +1. A second clean press -> one more pulse. key_step presses in RUN -> no extra pulses.
5. In PAUSE, press key_run and key_step identically, so the debounced presses coincide -> running=1, no immediate step_en; first pulse 16 cycles after entering RUN.
6. Assert rst for 1 cycle mid-run with counter=9, step_count=5 and a key mid-debounce -> next edge: step_en=0, running=1, step_count=0. No press is reported from the interrupted debounce. Pulses resume 16 cycles after release.
